// File: rtl/spi_link.sv
// spi_link: SPI mode-0 master and slave pair sharing one clock domain.
// The master drives sck/cs/mosi; the slave observes only those bus signals
// and answers on miso. Both sides exchange one WORD_SIZE word, MSB first.
module spi_link #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] m_data_in,
  input  logic                 s_load,
  input  logic [WORD_SIZE-1:0] s_data_in,
  output logic [WORD_SIZE-1:0] m_data_rcv,
  output logic [WORD_SIZE-1:0] s_data_rcv,
  output logic                 m_done,
  output logic                 s_done,
  output logic                 m_busy,
  output logic                 sck,
  output logic                 cs,
  output logic                 mosi,
  output logic                 miso
);

  localparam int unsigned W     = WORD_SIZE;
  localparam int unsigned CNT_W = $clog2(WORD_SIZE + 1);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Master registers
  state_t           state_q, state_d;
  logic [W-1:0]     tx_m_q, tx_m_d;
  logic [W-1:0]     rx_m_q, rx_m_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             cs_q, cs_d;
  logic             m_done_q, m_done_d;
  logic             m_busy_q, m_busy_d;
  logic [W-1:0]     m_data_rcv_q, m_data_rcv_d;

  // Slave registers
  logic             s_sck_q, s_sck_d;
  logic [W-1:0]     tx_s_q, tx_s_d;
  logic [W-1:0]     rx_s_q, rx_s_d;
  logic [CNT_W-1:0] s_cnt_q, s_cnt_d;
  logic [W-1:0]     s_data_rcv_q, s_data_rcv_d;
  logic             s_done_q, s_done_d;

  logic             s_rise;
  logic             s_fall;

  assign sck        = sck_q;
  assign cs         = cs_q;
  assign m_done     = m_done_q;
  assign m_busy     = m_busy_q;
  assign m_data_rcv = m_data_rcv_q;
  assign s_done     = s_done_q;
  assign s_data_rcv = s_data_rcv_q;
  assign mosi       = ~cs_q & tx_m_q[W-1];
  assign miso       = ~cs & tx_s_q[W-1];

  // Master next-state: phase divider, sck generation, shift and capture
  always_comb begin
    state_d      = state_q;
    tx_m_d       = tx_m_q;
    rx_m_d       = rx_m_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    sck_d        = sck_q;
    cs_d         = cs_q;
    m_done_d     = 1'b0;
    m_busy_d     = m_busy_q;
    m_data_rcv_d = m_data_rcv_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_m_d    = m_data_in;
          bit_cnt_d = '0;
          div_d     = '0;
          cs_d      = 1'b0;
          m_busy_d  = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d  = 1'b1;
            rx_m_d = {rx_m_q[W-2:0], miso};
          end else begin
            sck_d  = 1'b0;
            tx_m_d = {tx_m_q[W-2:0], 1'b0};
            if (bit_cnt_q == CNT_W'(W - 1)) begin
              state_d      = ST_DONE;
              cs_d         = 1'b1;
              m_done_d     = 1'b1;
              m_data_rcv_d = rx_m_q;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        m_busy_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        m_busy_d = 1'b0;
        cs_d     = 1'b1;
        sck_d    = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Master state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tx_m_q       <= '0;
      rx_m_q       <= '0;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      sck_q        <= 1'b0;
      cs_q         <= 1'b1;
      m_done_q     <= 1'b0;
      m_busy_q     <= 1'b0;
      m_data_rcv_q <= '0;
    end else begin
      state_q      <= state_d;
      tx_m_q       <= tx_m_d;
      rx_m_q       <= rx_m_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      sck_q        <= sck_d;
      cs_q         <= cs_d;
      m_done_q     <= m_done_d;
      m_busy_q     <= m_busy_d;
      m_data_rcv_q <= m_data_rcv_d;
    end
  end

  // Slave sck edge detection, qualified by an asserted chip select
  assign s_rise = ~cs & sck & ~s_sck_q;
  assign s_fall = ~cs & ~sck & s_sck_q;

  // Slave next-state: load while deselected, sample on rise, shift on fall
  always_comb begin
    s_sck_d      = sck;
    tx_s_d       = tx_s_q;
    rx_s_d       = rx_s_q;
    s_cnt_d      = s_cnt_q;
    s_data_rcv_d = s_data_rcv_q;
    s_done_d     = 1'b0;
    if (cs) begin
      s_cnt_d = '0;
      if (s_load) begin
        tx_s_d = s_data_in;
      end
    end else if (s_rise) begin
      rx_s_d  = {rx_s_q[W-2:0], mosi};
      s_cnt_d = s_cnt_q + CNT_W'(1);
      if (s_cnt_q == CNT_W'(W - 1)) begin
        s_data_rcv_d = {rx_s_q[W-2:0], mosi};
        s_done_d     = 1'b1;
        // The final sck fall coincides with cs rising and is never seen,
        // so the fully consumed word is cleared here instead.
        tx_s_d       = '0;
      end
    end else if (s_fall) begin
      tx_s_d = {tx_s_q[W-2:0], 1'b0};
    end
  end

  // Slave register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sck_q      <= 1'b0;
      tx_s_q       <= '0;
      rx_s_q       <= '0;
      s_cnt_q      <= '0;
      s_data_rcv_q <= '0;
      s_done_q     <= 1'b0;
    end else begin
      s_sck_q      <= s_sck_d;
      tx_s_q       <= tx_s_d;
      rx_s_q       <= rx_s_d;
      s_cnt_q      <= s_cnt_d;
      s_data_rcv_q <= s_data_rcv_d;
      s_done_q     <= s_done_d;
    end
  end

endmodule

// File: tb/tb_spi_link.sv
// tb_spi_link: directed transfers against a transaction-level model of the
// SPI link, with a per-cycle compare process and literal end-of-transfer checks.
module tb_spi_link;

  localparam int W = 8;
  localparam int D = 2;
  localparam int XFER = 2 * W * D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] m_data_in = '0;
  logic         s_load = 1'b0;
  logic [W-1:0] s_data_in = '0;
  logic [W-1:0] m_data_rcv;
  logic [W-1:0] s_data_rcv;
  logic         m_done;
  logic         s_done;
  logic         m_busy;
  logic         sck;
  logic         cs;
  logic         mosi;
  logic         miso;

  int n_checks = 0;
  int n_pass = 0;

  spi_link #(.WORD_SIZE(W), .CLK_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .m_data_in  (m_data_in),
    .s_load     (s_load),
    .s_data_in  (s_data_in),
    .m_data_rcv (m_data_rcv),
    .s_data_rcv (s_data_rcv),
    .m_done     (m_done),
    .s_done     (s_done),
    .m_busy     (m_busy),
    .sck        (sck),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: phase 0 idle, 1 transferring (t = edges since start), 2 done cycle
  int           phase = 0;
  int           t = 0;
  logic [W-1:0] cur_m = '0;
  logic [W-1:0] cur_s = '0;
  logic [W-1:0] s_tx = '0;
  logic [W-1:0] m_rcv = '0;
  logic [W-1:0] s_rcv = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 0;
      t     <= 0;
      s_tx  <= '0;
      m_rcv <= '0;
      s_rcv <= '0;
    end else begin
      case (phase)
        0: begin
          if (s_load) s_tx <= s_data_in;
          if (start) begin
            phase <= 1;
            t     <= 0;
            cur_m <= m_data_in;
            cur_s <= s_load ? s_data_in : s_tx;
          end
        end
        1: begin
          if (t + 1 == XFER) begin
            phase <= 2;
            m_rcv <= cur_s;
            s_rcv <= cur_m;
            s_tx  <= '0;
          end
          t <= t + 1;
        end
        default: begin
          if (s_load) s_tx <= s_data_in;
          phase <= 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of the bus and status outputs against the model
  int   sd_cnt = 0;
  logic prev_s_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cs", 32'(cs), 32'(1));
      chk("rst_sck", 32'(sck), 32'(0));
      chk("rst_m_done", 32'(m_done), 32'(0));
      chk("rst_s_done", 32'(s_done), 32'(0));
      chk("rst_m_busy", 32'(m_busy), 32'(0));
      chk("rst_m_rcv", 32'(m_data_rcv), 32'(0));
      chk("rst_s_rcv", 32'(s_data_rcv), 32'(0));
      sd_cnt = 0;
    end else begin
      chk("cs", 32'(cs), 32'(phase != 1));
      chk("m_busy", 32'(m_busy), 32'(phase != 0));
      chk("m_done", 32'(m_done), 32'(phase == 2));
      chk("m_data_rcv", 32'(m_data_rcv), 32'(m_rcv));
      if (phase == 1) begin
        chk("sck", 32'(sck), 32'((t % (2 * D)) >= D));
        chk("mosi", 32'(mosi), 32'(cur_m[W - 1 - t / (2 * D)]));
        if ((t % (2 * D)) == D - 1)
          chk("miso", 32'(miso), 32'(cur_s[W - 1 - t / (2 * D)]));
      end else begin
        chk("sck_idle", 32'(sck), 32'(0));
        chk("mosi_idle", 32'(mosi), 32'(0));
        chk("miso_idle", 32'(miso), 32'(0));
        chk("s_data_rcv", 32'(s_data_rcv), 32'(s_rcv));
      end
      if (s_done) begin
        chk("s_done_window", 32'(phase == 1 && t >= (2 * W - 1) * D && t < XFER), 32'(1));
        chk("s_done_width", 32'(prev_s_done), 32'(0));
        sd_cnt++;
      end
      if (phase == 2) chk("s_done_count", 32'(sd_cnt), 32'(1));
      if (phase == 0) sd_cnt = 0;
    end
    prev_s_done = s_done;
  end

  // One transfer; mode 0 plain, 1 start held, 2 start re-pulsed, 3 s_load mid-transfer
  task automatic run_xfer(input logic [W-1:0] mw, input logic ld, input logic [W-1:0] sw,
                          input int mode, input logic [W-1:0] exp_m, input logic [W-1:0] exp_s);
    int   k;
    int   rises;
    logic prev_sck;
    logic cs_ok;
    logic seen;
    s_load    = ld;
    s_data_in = sw;
    m_data_in = mw;
    start     = 1'b1;
    @(posedge clk); #1;
    s_load   = 1'b0;
    start    = (mode == 1);
    k        = 0;
    rises    = 0;
    prev_sck = 1'b0;
    cs_ok    = 1'b1;
    seen     = 1'b0;
    while (!seen && k < 200) begin
      if (mode == 2) start = (k == 9 || k == 20);
      if (mode == 3) begin
        s_load    = (k == 10);
        s_data_in = 8'hff;
      end
      @(posedge clk); #1;
      k++;
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
      if (m_done) seen = 1'b1;
      else if (cs) cs_ok = 1'b0;
    end
    start  = 1'b0;
    s_load = 1'b0;
    chk("m_done_seen", 32'(seen), 32'(1));
    chk("m_done_cycle", 32'(k), 32'(32));
    chk("sck_rises", 32'(rises), 32'(8));
    chk("cs_low_throughout", 32'(cs_ok), 32'(1));
    chk("m_word", 32'(m_data_rcv), 32'(exp_m));
    chk("s_word", 32'(s_data_rcv), 32'(exp_s));
    @(posedge clk); #1;
    chk("m_done_one_cycle", 32'(m_done), 32'(0));
    chk("back_to_idle", 32'(m_busy), 32'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mosi", 32'(mosi), 32'(0));
    chk("reset_miso", 32'(miso), 32'(0));
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_cs", 32'(cs), 32'(1));
    chk("idle_busy", 32'(m_busy), 32'(0));
    chk("idle_m_rcv", 32'(m_data_rcv), 32'(0));

    run_xfer(8'h4c, 1'b1, 8'haa, 0, 8'haa, 8'h4c);
    run_xfer(8'h42, 1'b1, 8'hca, 0, 8'hca, 8'h42);
    run_xfer(8'h22, 1'b1, 8'hdd, 0, 8'hdd, 8'h22);
    run_xfer(8'h11, 1'b1, 8'hee, 0, 8'hee, 8'h11);
    run_xfer(8'h5a, 1'b1, 8'h3c, 1, 8'h3c, 8'h5a);
    run_xfer(8'h69, 1'b1, 8'h81, 2, 8'h81, 8'h69);
    run_xfer(8'ha5, 1'b1, 8'h96, 3, 8'h96, 8'ha5);
    run_xfer(8'h0f, 1'b0, 8'h77, 0, 8'h00, 8'h0f);

    // Abort during the high phase of bit 4
    s_load    = 1'b1;
    s_data_in = 8'h81;
    m_data_in = 8'hc3;
    start     = 1'b1;
    @(posedge clk); #1;
    s_load = 1'b0;
    start  = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_abort_sck", 32'(sck), 32'(1));
    chk("pre_abort_cs", 32'(cs), 32'(0));
    rst = 1'b1;
    #1;
    chk("abort_cs", 32'(cs), 32'(1));
    chk("abort_sck", 32'(sck), 32'(0));
    chk("abort_busy", 32'(m_busy), 32'(0));
    chk("abort_m_rcv", 32'(m_data_rcv), 32'(0));
    chk("abort_s_rcv", 32'(s_data_rcv), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_m_done", 32'(m_done), 32'(0));
      chk("abort_no_s_done", 32'(s_done), 32'(0));
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_xfer(8'he7, 1'b1, 8'h18, 0, 8'h18, 8'he7);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
